// File: rtl/vic_pkg.sv
// vic_pkg: shared constants and types for the nested vectored interrupt
// controller (vic_nested) and its context stack (vic_ctx_stack).
//   PRIO_W / PC_W / CC_W : datapath widths; ctx_t is built from these.
//   GCTRL_ADDR           : register address of the global control register.
//   IDLE_PRIO            : current-priority encoding when no handler runs
//                          (MSB set = below every real level).
//   ST_*                 : FSM state codes; state_e names them.
//   ctx_t                : one saved context {pc, ccodes, prio}.
package vic_pkg;

  localparam int PRIO_W     = 3;
  localparam int PC_W       = 32;
  localparam int CC_W       = 4;
  localparam int GCTRL_ADDR = 0;

  localparam logic [PRIO_W:0] IDLE_PRIO = {1'b1, {PRIO_W{1'b0}}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENTER  = 2'd1;
  localparam logic [1:0] ST_RETURN = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ENTER  = ST_ENTER,
    RETURN = ST_RETURN
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [CC_W-1:0]   ccodes;
    logic [PRIO_W:0]   prio;
  } ctx_t;

  // True when a source priority strictly outranks the running priority.
  // An idle current priority (MSB set) is outranked by every level.
  function automatic logic outranks(input logic [PRIO_W-1:0] p,
                                    input logic [PRIO_W:0]   cur);
    return cur[PRIO_W] || ({1'b0, p} > cur);
  endfunction

endpackage

// File: rtl/vic_nested_if.sv
// vic_nested_if: core/bus-side signals of the nested VIC.
//   slave  : the controller (inputs i_*, outputs o_*).
//   master : the core / register bus / interrupt lines driving it.
// Register bus: i_VIC_regaddr, i_VIC_data, i_VIC_we, o_VIC_data (comb read).
// Core side   : i_PC, i_CCodes, i_reti in; o_VIC_ctrl, o_VIC_iaddr, o_CCodes out.
// Sources     : i_ext[NUM_SRC-1:0], source k is i_ext[k-1].
interface vic_nested_if
  import vic_pkg::*;
#(
  parameter int NUM_SRC = 31
);
  localparam int AW = $clog2(NUM_SRC + 1);

  logic [PC_W-1:0]    i_PC;
  logic [PRIO_W:0]    i_VIC_data;
  logic [AW-1:0]      i_VIC_regaddr;
  logic               i_VIC_we;
  logic [NUM_SRC-1:0] i_ext;
  logic               i_reti;
  logic [CC_W-1:0]    i_CCodes;
  logic [CC_W-1:0]    o_CCodes;
  logic [PRIO_W:0]    o_VIC_data;
  logic [PC_W-1:0]    o_VIC_iaddr;
  logic               o_VIC_ctrl;

  modport master (
    output i_PC, i_VIC_data, i_VIC_regaddr, i_VIC_we, i_ext, i_reti, i_CCodes,
    input  o_CCodes, o_VIC_data, o_VIC_iaddr, o_VIC_ctrl
  );

  modport slave (
    input  i_PC, i_VIC_data, i_VIC_regaddr, i_VIC_we, i_ext, i_reti, i_CCodes,
    output o_CCodes, o_VIC_data, o_VIC_iaddr, o_VIC_ctrl
  );

endinterface

// File: rtl/vic_ctx_stack.sv
// vic_ctx_stack: DEPTH-entry LIFO of saved interrupt contexts.
//   clk, rst  : clock, synchronous active-low reset (empties and clears).
//   push, din : store din on top (ignored when full).
//   pop       : discard top (ignored when empty).
//   top       : current top entry; meaningful only while depth != 0.
//   depth     : number of stored entries; full = (depth == DEPTH).
// The controller never pushes and pops in the same cycle.
module vic_ctx_stack
  import vic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  ctx_t                       din,
  output ctx_t                       top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ctx_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      depth <= '0;
      // NOTE: the stack storage is cleared on reset too, so a reset taken
      // mid-handler leaves no stale context that could ever be popped back.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[depth[IW-1:0]] <= din;
      depth              <= depth + 1'b1;
    end else if (pop && depth != '0) begin
      depth <= depth - 1'b1;
    end
  end

  assign top  = mem[IW'(depth - 1'b1)];
  assign full = (depth == DW'(DEPTH));

endmodule

// File: rtl/vic_nested.sv
// vic_nested: nested vectored interrupt controller.
//   clk  : system clock, rising edge.
//   rst  : synchronous active-low reset.
//   bus  : vic_nested_if.slave -- register bus, interrupt lines, core side.
// Registers: addr 0 GCTRL {stack_full, 0.., level_mode, global_enable};
//            addr k (1..NUM_SRC) SRCk {enable, prio}.
// Entry pushes {i_PC, i_CCodes, old priority} and pulses o_VIC_ctrl with
// o_VIC_iaddr = VEC_BASE + k*VEC_STRIDE; i_reti pops and pulses o_VIC_ctrl
// with the saved PC and condition codes.
// Optional: `define VIC_LEVEL_TRIG_EN adds GCTRL bit1 (level-triggered mode).
module vic_nested
  import vic_pkg::*;
#(
  parameter int              NUM_SRC    = 31,
  parameter int              DEPTH      = 4,
  parameter logic [PC_W-1:0] VEC_BASE   = 32'h0000_0100,
  parameter int              VEC_STRIDE = 4
) (
  input logic         clk,
  input logic         rst,
  vic_nested_if.slave bus
);
  localparam int AW = $clog2(NUM_SRC + 1);
  localparam int DW = $clog2(DEPTH + 1);

  logic [PRIO_W:0]    src_cfg [1:NUM_SRC];
  logic               gen_q;
  logic               lvl;
  logic [NUM_SRC:1]   pend_q, pend_nx, pend_eff;
  logic [NUM_SRC-1:0] ext_q;
  logic [PRIO_W:0]    cur_prio;
  logic [1:0]         state;
  logic               ctrl_q;
  logic [PC_W-1:0]    iaddr_q;
  logic [CC_W-1:0]    cc_q;

  logic               win_vld;
  logic [AW-1:0]      win_idx;
  logic [PRIO_W-1:0]  win_prio;
  logic               take, ret_go, full, cfg_hit;
  logic [DW-1:0]      depth;
  ctx_t               push_ctx, top_ctx;
  logic [PRIO_W:0]    gctrl_rd;

`ifdef VIC_LEVEL_TRIG_EN
  logic lvl_q;
  assign lvl      = lvl_q;
  assign pend_eff = lvl_q ? bus.i_ext : pend_q;
`else
  assign lvl      = 1'b0;
  assign pend_eff = pend_q;
`endif

  assign cfg_hit  = (bus.i_VIC_regaddr != '0) && (int'(bus.i_VIC_regaddr) <= NUM_SRC);
  assign ret_go   = (state == ST_IDLE) && bus.i_reti && (depth != '0);
  assign take     = (state == ST_IDLE) && !ret_go && win_vld;
  assign push_ctx = '{pc: bus.i_PC, ccodes: bus.i_CCodes, prio: cur_prio};

  vic_ctx_stack #(.DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (take),
    .pop   (ret_go),
    .din   (push_ctx),
    .top   (top_ctx),
    .depth (depth),
    .full  (full)
  );

  // Highest priority wins; the strict '>' keeps the lowest index on ties.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned (which would infer a latch); blocking '='
    // is used here because later loop iterations must see earlier results.
    win_vld  = 1'b0;
    win_idx  = '0;
    win_prio = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (pend_eff[k] && src_cfg[k][PRIO_W] && gen_q && !full &&
          outranks(src_cfg[k][PRIO_W-1:0], cur_prio) &&
          (!win_vld || src_cfg[k][PRIO_W-1:0] > win_prio)) begin
        win_vld  = 1'b1;
        win_idx  = AW'(k);
        win_prio = src_cfg[k][PRIO_W-1:0];
      end
    end
  end

  // Pending bits: rising edges set; taking a source or disabling it clears.
  always_comb begin
    pend_nx = pend_q | (bus.i_ext & ~ext_q);
    if (take) pend_nx[win_idx] = 1'b0;
    if (bus.i_VIC_we && cfg_hit && !bus.i_VIC_data[PRIO_W])
      pend_nx[bus.i_VIC_regaddr] = 1'b0;
  end

  always_comb begin
    gctrl_rd         = '0;
    gctrl_rd[PRIO_W] = full;
    gctrl_rd[1]      = lvl;
    gctrl_rd[0]      = gen_q;
    bus.o_VIC_data   = '0;
    if (bus.i_VIC_regaddr == AW'(GCTRL_ADDR)) bus.o_VIC_data = gctrl_rd;
    else if (cfg_hit)                         bus.o_VIC_data = src_cfg[bus.i_VIC_regaddr];
  end

  // NOTE: all state below uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gen_q    <= 1'b0;
`ifdef VIC_LEVEL_TRIG_EN
      lvl_q    <= 1'b0;
`endif
      pend_q   <= '0;
      ext_q    <= '0;
      cur_prio <= IDLE_PRIO;
      state    <= ST_IDLE;
      ctrl_q   <= 1'b0;
      iaddr_q  <= '0;
      cc_q     <= '0;
      for (int k = 1; k <= NUM_SRC; k++) src_cfg[k] <= '0;
    end else begin
      ext_q  <= bus.i_ext;
      pend_q <= pend_nx;
      ctrl_q <= 1'b0;

      if (bus.i_VIC_we) begin
        if (bus.i_VIC_regaddr == AW'(GCTRL_ADDR)) begin
          gen_q <= bus.i_VIC_data[0];
`ifdef VIC_LEVEL_TRIG_EN
          lvl_q <= bus.i_VIC_data[1];
`endif
        end else if (cfg_hit) begin
          src_cfg[bus.i_VIC_regaddr] <= bus.i_VIC_data;
        end
      end

      // ENTER and RETURN last one cycle, which keeps o_VIC_ctrl from ever
      // being high two cycles in a row.
      case (state)
        ST_IDLE: begin
          if (ret_go) begin
            state    <= ST_RETURN;
            ctrl_q   <= 1'b1;
            iaddr_q  <= top_ctx.pc;
            cc_q     <= top_ctx.ccodes;
            cur_prio <= top_ctx.prio;
          end else if (take) begin
            state    <= ST_ENTER;
            ctrl_q   <= 1'b1;
            iaddr_q  <= VEC_BASE + PC_W'(win_idx) * PC_W'(VEC_STRIDE);
            cur_prio <= {1'b0, win_prio};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_VIC_ctrl  = ctrl_q;
  assign bus.o_VIC_iaddr = iaddr_q;
  assign bus.o_CCodes    = cc_q;

endmodule

// File: doc/vic_nested.md
Name: vic_nested

Overview:
- Parametrised nested vectored interrupt controller; successor to the flat single-level VIC.
- Sits between the external interrupt lines and the core fetch stage.
- Latches requests from NUM_SRC sources and arbitrates them by programmable priority.
- Redirects fetch to a per-source vector and preempts a running handler only for a strictly higher priority.
- Saves and restores {PC, CCodes} on a DEPTH-entry context stack.

Parameters:
- NUM_SRC, 31: number of interrupt sources; source k (1..NUM_SRC) is i_ext[k-1].
- PRIO_W, 3: priority field width; larger value means more urgent.
- DEPTH, 4: maximum nesting depth (context stack entries).
- PC_W, 32: program counter width.
- CC_W, 4: condition-code width.
- VEC_BASE, 32'h0000_0100: address of vector 0.
- VEC_STRIDE, 4: byte spacing between vectors.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- i_PC  in  PC_W  PC of the next instruction; saved on entry.
- i_VIC_data  in  PRIO_W+1  register write data.
- i_VIC_regaddr  in  clog2(NUM_SRC+1)  register address.
- i_VIC_we  in  1  register write enable.
- i_ext  in  NUM_SRC  raw interrupt request lines.
- i_reti  in  1  one-cycle return-from-interrupt strobe.
- i_CCodes  in  CC_W  live condition codes; saved on entry.
- o_CCodes  out  CC_W  condition codes to restore; valid while o_VIC_ctrl is high on return.
- o_VIC_data  out  PRIO_W+1  combinational read of the register at i_VIC_regaddr.
- o_VIC_iaddr  out  PC_W  fetch-redirect address.
- o_VIC_ctrl  out  1  one-cycle pulse: core loads o_VIC_iaddr into PC (and o_CCodes on return).

Behaviour:
- Reset (rst==0 at a clk edge):
  - All config regs, pending bits, edge history and stack cleared; depth=0; current priority = idle (below every level).
  - o_VIC_ctrl=0, o_VIC_iaddr=0, o_CCodes=0. o_VIC_data follows the cleared regs.
  - Reset mid-handler discards all context.
- Register map:
  - Addr 0: GCTRL, bit0 = global enable. Read returns {stack_full, 0.., global_enable}.
  - Addr k (1..NUM_SRC): SRCk = {enable[PRIO_W], prio[PRIO_W-1:0]}.
  - Writes take effect at the clk edge with i_VIC_we=1. Writes to addresses above NUM_SRC are ignored; reads there return 0.
- Request capture:
  - Rising edge on i_ext[k-1] (current high, previous cycle low) sets pend[k].
  - pend[k] is set regardless of enable; it is cleared only when source k is taken, or when SRCk is written with enable=0.
- Arbitration (combinational):
  - Eligible = pend & enable & global_enable & (prio > current priority) & !stack_full.
  - Winner = highest prio; ties go to the lowest index.
- FSM states: IDLE, ENTER, RETURN.
  - IDLE -> RETURN when i_reti==1 and depth>0. i_reti with depth==0 is ignored.
  - IDLE -> ENTER when a winner exists and i_reti==0. When both occur in the same cycle, reti wins and the request is re-evaluated from IDLE.
  - ENTER (1 cycle):
    - Push {i_PC, i_CCodes, old current priority}; depth++.
    - Current priority = winner prio; clear pend[winner].
    - Drive o_VIC_ctrl=1, o_VIC_iaddr = VEC_BASE + winner*VEC_STRIDE. Return to IDLE.
  - RETURN (1 cycle):
    - Pop; drive o_VIC_ctrl=1, o_VIC_iaddr = saved PC, o_CCodes = saved CCodes.
    - Restore current priority; depth--. Return to IDLE.
- Latency:
  - The edge on i_ext is seen at edge N and sets pend at edge N.
  - FSM enters ENTER at edge N+1; o_VIC_ctrl is high in the cycle after edge N+1.
  - Return: i_reti at edge M -> o_VIC_ctrl high in the cycle after edge M.
- Boundaries:
  - stack_full (depth==DEPTH) blocks preemption; requests stay pending.
  - Equal priority never preempts.
  - Outputs are registered and held between pulses; o_VIC_ctrl is never high two consecutive cycles.
- Vector address arithmetic is modulo 2^PC_W.

Optional Feature:
- Macro: VIC_LEVEL_TRIG_EN.
- Defined: adds GCTRL bit1 = level mode.
  - When set, pend[k] = i_ext[k-1] directly, with no latching.
  - Handler must deassert the line before reti to avoid immediate re-entry.
- Undefined: GCTRL bit1 reads 0 and writes to it are ignored; edge-triggered only.

Decomposition:
- vic_pkg:
  - GCTRL address constant.
  - FSM state enum {IDLE, ENTER, RETURN}.
  - ctx_t struct {pc, ccodes, prio}.
  - IDLE_PRIO encoding (PRIO_W+1 bits, MSB=1 means idle).
- Sub-module vic_ctx_stack:
  - Parametrised LIFO of ctx_t with push, pop, top, depth and full outputs.
  - Simultaneous push and pop never occurs (guaranteed by FSM).

Test Plan:
- Reset, write SRC1=4'b1100 (en, prio 4), GCTRL=1, i_PC=0x40, pulse i_ext=1 -> o_VIC_ctrl pulse 2 cycles later, o_VIC_iaddr=0x104.
- While in src1, raise i_ext[1] with SRC2=en prio 6 -> preempt, iaddr=0x108, depth=2. Then i_reti -> iaddr = PC saved at src2 entry, o_CCodes restored.
- Nested src1 (prio 4), then src3 at prio 4 -> no preemption; after i_reti, src3 taken on the following arbitration.
- DEPTH=4, five escalating priorities -> fifth stays pending with GCTRL read bit showing full; taken after one reti.
- i_reti at depth 0 -> no o_VIC_ctrl. Simultaneous i_reti and new request at depth 1 -> RETURN first, then ENTER.
- With VIC_LEVEL_TRIG_EN and level mode: hold i_ext[0] high through reti -> immediate re-entry. Drop it before reti -> no re-entry.
